// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI memory engine between the fetch (F) and data (D) ports,
// with a watchdog that aborts a transaction the engine never completes.
module spi_bus_arbiter #(
   parameter int unsigned ADDR_W  = 16,
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              f_req,
   input  logic [ADDR_W-1:0] f_addr,
   output logic              f_ack,
   output logic              f_err,
   output logic [DATA_W-1:0] f_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic              d_err,
   output logic [DATA_W-1:0] d_rdata,
   output logic              eng_start,
   output logic              eng_we,
   output logic [ADDR_W-1:0] eng_addr,
   output logic [DATA_W-1:0] eng_wdata,
   output logic              eng_abort,
   input  logic              eng_busy,
   input  logic              eng_done,
   input  logic [DATA_W-1:0] eng_rdata,
   output logic              owner
);

   localparam int unsigned      CNT_W   = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

   typedef enum logic [2:0] {StIdle, StIssue, StWait, StResp, StRecover} state_e;

   state_e           state;
   logic             last_d;
   logic [CNT_W-1:0] wdog;
   logic             grant_d;
   logic             timeout;

   // On a tie the port that was not served last wins.
   assign grant_d = d_req && (!f_req || !last_d);

   // A completion arriving on the final watchdog cycle takes precedence over the abort.
   assign timeout   = (state == StWait) && !eng_done && (wdog == CNT_MAX);
   assign eng_start = (state == StIssue) && !eng_busy;
   assign eng_abort = timeout;
   assign f_err     = timeout && !owner;
   assign d_err     = timeout && owner;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= StIdle;
         last_d    <= 1'b1;
         owner     <= 1'b0;
         wdog      <= '0;
         eng_we    <= 1'b0;
         eng_addr  <= '0;
         eng_wdata <= '0;
         f_ack     <= 1'b0;
         d_ack     <= 1'b0;
         f_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         f_ack <= 1'b0;
         d_ack <= 1'b0;
         unique case (state)
            StIdle: begin
               if (f_req || d_req) begin
                  owner     <= grant_d;
                  last_d    <= grant_d;
                  eng_we    <= grant_d && d_we;
                  eng_addr  <= grant_d ? d_addr : f_addr;
                  eng_wdata <= grant_d ? d_wdata : '0;
                  state     <= StIssue;
               end
            end
            StIssue: begin
               if (!eng_busy) begin
                  wdog  <= '0;
                  state <= StWait;
               end
            end
            StWait: begin
               if (eng_done) begin
                  if (owner) begin
                     d_ack <= 1'b1;
                     if (!eng_we) d_rdata <= eng_rdata;
                  end else begin
                     f_ack   <= 1'b1;
                     f_rdata <= eng_rdata;
                  end
                  state <= StResp;
               end else if (wdog == CNT_MAX) begin
                  state <= StRecover;
               end else begin
                  wdog <= wdog + CNT_W'(1);
               end
            end
            StResp: state <= StIdle;
            StRecover: begin
               if (!eng_busy) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter: arbitration order, handshake latency, write path,
// watchdog abort/recovery, busy-delayed start and mid-transaction reset.
module tb_spi_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        f_req, d_req, d_we;
   logic [15:0] f_addr, d_addr, d_wdata;
   logic        f_ack, f_err, d_ack, d_err;
   logic [15:0] f_rdata, d_rdata;
   logic        eng_start, eng_we, eng_abort, eng_busy, eng_done;
   logic [15:0] eng_addr, eng_wdata, eng_rdata;
   logic        owner;

   int n_vec = 0;
   int n_bad = 0;
   int n_start = 0, n_fack = 0, n_dack = 0, n_ferr = 0, n_derr = 0, n_abort = 0, n_both = 0;

   spi_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .TIMEOUT(8)) dut (
      .clk(clk), .rst(rst),
      .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_err(f_err), .f_rdata(f_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
      .eng_start(eng_start), .eng_we(eng_we), .eng_addr(eng_addr), .eng_wdata(eng_wdata),
      .eng_abort(eng_abort), .eng_busy(eng_busy), .eng_done(eng_done),
      .eng_rdata(eng_rdata), .owner(owner)
   );

   always #5 clk = ~clk;

   // Pulse counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (eng_start) n_start <= n_start + 1;
      if (f_ack) n_fack <= n_fack + 1;
      if (d_ack) n_dack <= n_dack + 1;
      if (f_err) n_ferr <= n_ferr + 1;
      if (d_err) n_derr <= n_derr + 1;
      if (eng_abort) n_abort <= n_abort + 1;
      if ((f_ack || d_ack) && (f_err || d_err)) n_both <= n_both + 1;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Returns at the negedge of the cycle in which eng_start is seen; cyc counts edges waited.
   task automatic wait_start(output int cyc);
      bit seen;
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 50) begin
         @(negedge clk);
         if (eng_start) seen = 1;
         else begin
            @(posedge clk); #1;
            cyc++;
         end
      end
      if (!seen) check("eng_start timeout", 32'd0, 32'd1);
   endtask

   // Engine model: busy from the cycle after start, done 'lat' cycles after start.
   task automatic respond(input int lat, input logic [15:0] rd);
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         eng_busy = 1'b1;
         if (k == lat) begin
            eng_done  = 1'b1;
            eng_rdata = rd;
         end
      end
      @(posedge clk); #1;
      eng_busy = 1'b0;
      eng_done = 1'b0;
   endtask

   task automatic serve_one(input string tag, input logic own, input logic [15:0] addr,
                            input int lat, input logic [15:0] rd, input int exp_lat);
      int cyc;
      wait_start(cyc);
      check({tag, " start latency"}, cyc, exp_lat);
      check({tag, " owner"}, owner, own);
      check({tag, " eng_addr"}, eng_addr, addr);
      check({tag, " eng_we"}, eng_we, 1'b0);
      respond(lat, rd);
      @(negedge clk);
      check({tag, " f_ack"}, f_ack, !own);
      check({tag, " d_ack"}, d_ack, own);
      @(posedge clk); #1;
      if (own) d_req = 1'b0;
      else f_req = 1'b0;
      @(posedge clk); #1;
   endtask

   initial begin
      int cyc, s_start, s_fack, s_ferr, s_derr, s_abort;
      rst = 1'b1; f_req = 0; d_req = 0; d_we = 0; f_addr = 0; d_addr = 0; d_wdata = 0;
      eng_busy = 0; eng_done = 0; eng_rdata = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset owner", owner, 1'b0);
      check("reset eng_addr", eng_addr, 16'h0);
      check("reset eng_start", eng_start, 1'b0);
      check("reset f_rdata", f_rdata, 16'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Tie from reset: F first, then D; the next tie goes to F again.
      f_addr = 16'h0100; d_addr = 16'h0200; f_req = 1; d_req = 1;
      serve_one("t2 f", 1'b0, 16'h0100, 2, 16'h1111, 1);
      check("t2 f_rdata", f_rdata, 16'h1111);
      serve_one("t2 d", 1'b1, 16'h0200, 2, 16'h2222, 0);
      check("t2 d_rdata", d_rdata, 16'h2222);
      check("t2 f_rdata hold", f_rdata, 16'h1111);
      f_addr = 16'h0102; d_addr = 16'h0202; f_req = 1; d_req = 1;
      serve_one("t2 tie f", 1'b0, 16'h0102, 2, 16'h1112, 1);
      serve_one("t2 tie d", 1'b1, 16'h0202, 3, 16'h2223, 0);

      // Single fetch, done 4 cycles after start; then done on the last watchdog cycle.
      s_start = n_start; s_fack = n_fack; s_abort = n_abort; s_ferr = n_ferr;
      f_addr = 16'h0010; f_req = 1;
      serve_one("t1", 1'b0, 16'h0010, 4, 16'hA5C3, 1);
      check("t1 f_rdata", f_rdata, 16'hA5C3);
      check("t1 d_rdata hold", d_rdata, 16'h2223);
      f_addr = 16'h0020; f_req = 1;
      serve_one("t1 done wins", 1'b0, 16'h0020, 8, 16'h5A5A, 1);
      check("t1 f_rdata late", f_rdata, 16'h5A5A);
      check("t1 starts", n_start - s_start, 2);
      check("t1 f_acks", n_fack - s_fack, 2);
      check("t1 no abort", n_abort - s_abort, 0);
      check("t1 no f_err", n_ferr - s_ferr, 0);

      // Write; a fetch raised mid-write is served right after d_ack.
      s_start = n_start;
      d_req = 1; d_we = 1; d_addr = 16'h8002; d_wdata = 16'h00FF;
      wait_start(cyc);
      check("t3 start latency", cyc, 1);
      check("t3 owner", owner, 1'b1);
      check("t3 eng_we", eng_we, 1'b1);
      check("t3 eng_addr", eng_addr, 16'h8002);
      check("t3 eng_wdata", eng_wdata, 16'h00FF);
      f_addr = 16'h0300; f_req = 1;
      respond(3, 16'hBEEF);
      @(negedge clk);
      check("t3 d_ack", d_ack, 1'b1);
      check("t3 f_ack", f_ack, 1'b0);
      check("t3 d_rdata unchanged", d_rdata, 16'h2223);
      @(posedge clk); #1;
      d_req = 0; d_we = 0;
      @(posedge clk); #1;
      serve_one("t3 f", 1'b0, 16'h0300, 2, 16'h3333, 0);
      check("t3 starts", n_start - s_start, 2);

      // Engine busy at grant: start waits, then exactly one start.
      s_start = n_start;
      d_addr = 16'h0600; d_req = 1; eng_busy = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("t5 start held", eng_start, 1'b0);
         @(posedge clk); #1;
      end
      eng_busy = 0;
      serve_one("t5", 1'b1, 16'h0600, 2, 16'h5555, 0);
      check("t5 one start", n_start - s_start, 1);

      // Hung engine: abort + f_err 8 cycles after start, IDLE only after busy drops.
      s_fack = n_fack; s_ferr = n_ferr; s_derr = n_derr; s_abort = n_abort;
      f_addr = 16'h0400; f_req = 1;
      wait_start(cyc);
      check("t4 start latency", cyc, 1);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         eng_busy = 1;
         @(negedge clk);
         if (k < 8) check("t4 early abort", eng_abort, 1'b0);
      end
      check("t4 eng_abort", eng_abort, 1'b1);
      check("t4 f_err", f_err, 1'b1);
      check("t4 d_err", d_err, 1'b0);
      for (int j = 9; j <= 12; j++) begin
         @(posedge clk); #1;
         if (j == 9) begin
            f_req = 0; d_addr = 16'h0500; d_req = 1;
         end
         eng_busy = (j < 12);
         @(negedge clk);
         check("t4 no start in recover", eng_start, 1'b0);
      end
      check("t4 abort count", n_abort - s_abort, 1);
      check("t4 f_err count", n_ferr - s_ferr, 1);
      check("t4 no f_ack", n_fack - s_fack, 0);
      check("t4 no d_err", n_derr - s_derr, 0);
      @(posedge clk); #1;
      serve_one("t4 d after recover", 1'b1, 16'h0500, 2, 16'h4444, 1);

      // Reset in WAIT with a pending tie: outputs clear, F wins after reset.
      f_addr = 16'h0700; f_req = 1;
      wait_start(cyc);
      check("t6 start latency", cyc, 1);
      @(posedge clk); #1;
      eng_busy = 1; d_addr = 16'h0800; d_req = 1;
      @(posedge clk); #1;
      rst = 1;
      @(negedge clk);
      check("t6 rst owner", owner, 1'b0);
      check("t6 rst eng_addr", eng_addr, 16'h0);
      check("t6 rst f_rdata", f_rdata, 16'h0);
      check("t6 rst d_rdata", d_rdata, 16'h0);
      check("t6 rst acks", {f_ack, d_ack, f_err, d_err, eng_start, eng_abort}, 6'b0);
      @(posedge clk); #1;
      rst = 0; eng_busy = 0;
      serve_one("t6 f", 1'b0, 16'h0700, 2, 16'h6666, 1);
      serve_one("t6 d", 1'b1, 16'h0800, 2, 16'h7777, 0);
      check("t6 d_rdata", d_rdata, 16'h7777);

      check("never ack with err", n_both, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
